// File: rtl/neuron_mac.sv
// Single-neuron MAC stage: captures operands, runs N_IN MACs, then shift/activate/saturate.
// Define NEURON_RELU_EN for ReLU with unsigned output; the default is linear with signed output.
module neuron_mac #(
  parameter int N_IN     = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0
) (
  input  logic                     pi_clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [N_IN*WEIGHT_W-1:0] weights,
  input  logic [ACC_W-1:0]         bias,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [ACC_W-1:0]         out_acc
);

  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = DATA_W + 1 + WEIGHT_W;

  localparam logic signed [ACC_W-1:0] LIN_HI =
    ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] LIN_LO =
    -ACC_W'(1 << (OUT_W - 1));
  localparam logic signed [ACC_W-1:0] RELU_HI =
    ACC_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_POST,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [N_IN*DATA_W-1:0]    x_q, x_d;
  logic [N_IN*WEIGHT_W-1:0]  w_q, w_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [OUT_W-1:0]          data_q, data_d;
  logic [ACC_W-1:0]          oacc_q, oacc_d;

  logic [DATA_W-1:0]         x_sel;
  logic [WEIGHT_W-1:0]       w_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   s;
  logic [OUT_W-1:0]          sat;
  logic                      load;

  assign x_sel    = x_q[idx_q*DATA_W +: DATA_W];
  assign w_sel    = w_q[idx_q*WEIGHT_W +: WEIGHT_W];
  assign prod     = $signed({1'b0, x_sel}) * $signed(w_sel);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign s        = acc_q >>> SHIFT;

  always_comb begin
    sat = s[OUT_W-1:0];
`ifdef NEURON_RELU_EN
    if (s < 0)
      sat = '0;
    else if (s > RELU_HI)
      sat = '1;
`else
    if (s > LIN_HI)
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (s < LIN_LO)
      sat = {1'b1, {(OUT_W-1){1'b0}}};
`endif
  end

  // A handshake with start high re-arms directly without visiting IDLE.
  assign load = start && ((state_q == S_IDLE) ||
                (state_q == S_DONE && out_ready));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    oacc_d  = oacc_q;
    unique case (state_q)
      S_IDLE: begin
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_IN - 1)) begin
          idx_d   = '0;
          state_d = S_POST;
        end
      end
      S_POST: begin
        data_d  = sat;
        oacc_d  = acc_q;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      x_d     = in_data;
      w_d     = weights;
      acc_d   = $signed(bias);
      idx_d   = '0;
      busy_d  = 1'b1;
      state_d = S_MAC;
    end
  end

  always_ff @(posedge pi_clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oacc_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      oacc_q  <= oacc_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_acc   = oacc_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed vectors, monitor pops on handshake.
// Expected output bytes follow NEURON_RELU_EN when it is defined.
module tb_neuron_mac;

  localparam int N_IN = 4;
  localparam int DW   = 8;
  localparam int WW   = 8;
  localparam int AW   = 20;
  localparam int OW   = 8;

  logic               pi_clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [N_IN*DW-1:0] in_data;
  logic [N_IN*WW-1:0] weights;
  logic [AW-1:0]      bias;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [OW-1:0]      out_data;
  logic [AW-1:0]      out_acc;

  typedef struct {
    logic [AW-1:0] acc;
    logic [OW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  neuron_mac #(
    .N_IN(N_IN), .DATA_W(DW), .WEIGHT_W(WW),
    .ACC_W(AW), .OUT_W(OW), .SHIFT(0)
  ) dut (
    .pi_clk    (pi_clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .weights   (weights),
    .bias      (bias),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc)
  );

  always #5 pi_clk = ~pi_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge pi_clk) begin
    if (!rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got acc %0h, no result expected",
                 out_acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_acc", 32'(out_acc), 32'(e.acc));
        chk("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic launch(input logic [31:0] x, input logic [31:0] w,
                        input logic [AW-1:0] b, input bit push,
                        input logic [AW-1:0] eacc,
                        input logic [OW-1:0] elin,
                        input logic [OW-1:0] erelu);
    exp_t e;
    e.acc = eacc;
`ifdef NEURON_RELU_EN
    e.data = erelu;
`else
    e.data = elin;
`endif
    if (push) sb.push_back(e);
    in_data = x;
    weights = w;
    bias    = b;
    start   = 1'b1;
    @(posedge pi_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge pi_clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no out_valid, required within 50 cycles");
    end
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] w,
                     input logic [AW-1:0] b, input logic [AW-1:0] eacc,
                     input logic [OW-1:0] elin, input logic [OW-1:0] erelu);
    int n;
    out_ready = 1'b1;
    launch(x, w, b, 1'b1, eacc, elin, erelu);
    wait_valid(n);
    @(posedge pi_clk);
    #1;
  endtask

  initial begin
    int            n;
    bit            stable;
    bit            busy_ok;
    logic [AW-1:0] hacc;
    logic [OW-1:0] hdata;

    rst_n     = 1'b1;
    start     = 1'b0;
    in_data   = '0;
    weights   = '0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge pi_clk);
    #1;
    rst_n = 1'b0;
    @(posedge pi_clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_acc", 32'(out_acc), 0);

    // Basic sum, latency and single-cycle valid
    out_ready = 1'b1;
    launch({8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 20'd0, 1'b1,
           20'd10, 8'h0A, 8'h0A);
    wait_valid(n);
    chk("latency", 32'(n + 1), 32'(N_IN + 2));
    @(posedge pi_clk);
    #1;
    chk("valid_one_cycle", 32'(out_valid), 0);
    chk("busy_idle", 32'(busy), 0);

    run({4{8'd10}}, 32'hFFFFFFFF, 20'd0, 20'hFFFD8, 8'hD8, 8'h00);
    run({4{8'd255}}, 32'h7F7F7F7F, 20'd0, 20'h1FA04, 8'h7F, 8'hFF);
    run({4{8'd200}}, 32'h80808080, 20'd0, 20'hE7000, 8'h80, 8'h00);
    run(32'h0, 32'h0, 20'hFFFFB, 20'hFFFFB, 8'hFB, 8'h00);
    run({8'd0, 8'd0, 8'd100, 8'd100}, 32'h00000101, 20'd0,
        20'd200, 8'h7F, 8'hC8);

    // Backpressure with start and operand churn while held
    out_ready = 1'b0;
    launch({4{8'd1}}, 32'h02020202, 20'd1, 1'b1, 20'd9, 8'h09, 8'h09);
    wait_valid(n);
    hacc   = out_acc;
    hdata  = out_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start   = (i % 3) != 2;
      in_data = 32'($urandom);
      weights = 32'($urandom);
      @(posedge pi_clk);
      #1;
      if (!out_valid || !busy || out_acc !== hacc || out_data !== hdata)
        stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    chk("bp_acc", 32'(hacc), 9);
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge pi_clk);
    #1;
    chk("bp_valid_drop", 32'(out_valid), 0);
    chk("bp_busy_drop", 32'(busy), 0);
    repeat (3) @(posedge pi_clk);
    #1;
    chk("bp_no_queue", 32'(busy), 0);

    // Back-to-back: re-arm on the handshake edge
    out_ready = 1'b0;
    launch({8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 20'd0, 1'b1,
           20'd10, 8'h0A, 8'h0A);
    wait_valid(n);
    out_ready = 1'b1;
    launch({4{8'd2}}, 32'h03030303, 20'hFFFFC, 1'b1,
           20'd20, 8'h14, 8'h14);
    busy_ok = busy;
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge pi_clk);
      #1;
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    chk("b2b_latency", 32'(n), 32'(N_IN + 2));
    chk("b2b_busy_held", 32'(busy_ok), 1);
    chk("b2b_acc_now", 32'(out_acc), 20);
    @(posedge pi_clk);
    #1;

    // Reset mid-MAC discards the partial result
    launch({4{8'd9}}, 32'h05050505, 20'd7, 1'b0, 20'd0, 8'h0, 8'h0);
    repeat (2) @(posedge pi_clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_acc", 32'(out_acc), 0);
    #1;
    rst_n = 1'b0;
    @(posedge pi_clk);
    #1;
    run({8'd8, 8'd7, 8'd6, 8'd5}, 32'h0002FF01, 20'd100,
        20'd113, 8'h71, 8'h71);

    repeat (3) @(posedge pi_clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
